// File: rtl/exponent_accelerator_sw_pkg.sv
// Shared constants for the switch conditioning slave: register map, edge-type
// encodings and the per-bit debounce state.
package exponent_accelerator_sw_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_EDGE   = 2'd2;
    localparam logic [1:0] ADDR_PERIOD = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_CHANGING = 1'b1
    } db_state_t;

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch: 2-flop synchroniser feeding a tick-driven debounce FSM.
// flip_o pulses combinationally on the tick that accepts a new level (level_o still old).
module switch_debounce_bit
    import exponent_accelerator_sw_pkg::*;
#(
    parameter int STABLE_N = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic flip_o
);

    localparam int CNT_W = $clog2(STABLE_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

    logic [1:0]       sync_q;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             differ;

    assign differ  = sync_q[1] ^ level_q;
    assign level_o = level_q;
    assign flip_o  = tick_i && (state_q == DB_CHANGING) && differ && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (tick_i) begin
                unique case (state_q)
                    DB_STABLE: begin
                        if (differ) begin
                            state_q <= DB_CHANGING;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    DB_CHANGING: begin
                        // The STABLE_N-th differing sample commits the new level.
                        if (!differ) begin
                            state_q <= DB_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            level_q <= ~level_q;
                            state_q <= DB_STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/exponent_accelerator_switch_ctrl.sv
// Avalon-MM slave conditioning the board switches: debounced levels, sticky edges,
// maskable registered IRQ. Read latency 1, writes commit on the strobe edge.
module exponent_accelerator_switch_ctrl
    import exponent_accelerator_sw_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int PERIOD_W   = 16,
    parameter int PERIOD_RST = 50000,
    parameter int STABLE_N   = 4,
    parameter int EDGE_TYPE  = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             chipselect,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic                wr;
    logic                rd;
    logic                tick;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] tick_cnt_q;
    logic [PERIOD_W-1:0] tick_cnt_d;
    logic [WIDTH-1:0]    mask_q;
    logic [WIDTH-1:0]    edge_q;
    logic [WIDTH-1:0]    edge_d;
    logic [WIDTH-1:0]    level;
    logic [WIDTH-1:0]    flip;
    logic [WIDTH-1:0]    edge_ev;
    logic [WIDTH-1:0]    clr;
    logic [31:0]         rd_d;
    logic                unused_wd;

    assign wr        = chipselect & write;
    assign rd        = chipselect & read;
    assign tick      = (tick_cnt_q == period_q);
    assign unused_wd = ^writedata[31:PERIOD_W];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        switch_debounce_bit #(.STABLE_N(STABLE_N)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .tick_i  (tick),
            .raw_i   (in_port[i]),
            .level_o (level[i]),
            .flip_o  (flip[i])
        );
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + PERIOD_W'(1);
        if (wr && address == ADDR_PERIOD) begin
            tick_cnt_d = '0;
        end
    end

    // flip arrives alongside the pre-flip level, so the level gives the direction.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_ev = flip & ~level;
            EDGE_FALL: edge_ev = flip & level;
            default:   edge_ev = flip;
        endcase
        clr    = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        edge_d = edge_ev | (edge_q & ~clr);
    end

    always_comb begin
        rd_d = '0;
        if (rd) begin
            case (address)
                ADDR_DATA:   rd_d[WIDTH-1:0]    = level;
                ADDR_MASK:   rd_d[WIDTH-1:0]    = mask_q;
                ADDR_EDGE:   rd_d[WIDTH-1:0]    = edge_q;
                ADDR_PERIOD: rd_d[PERIOD_W-1:0] = period_q;
                default:     rd_d               = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata   <= '0;
            irq        <= 1'b0;
            mask_q     <= '0;
            edge_q     <= '0;
            period_q   <= PERIOD_W'(PERIOD_RST);
            tick_cnt_q <= '0;
        end else begin
            readdata   <= rd_d;
            irq        <= |(edge_q & mask_q);
            edge_q     <= edge_d;
            tick_cnt_q <= tick_cnt_d;
            if (wr) begin
                case (address)
                    ADDR_MASK:   mask_q   <= writedata[WIDTH-1:0];
                    ADDR_PERIOD: period_q <= writedata[PERIOD_W-1:0];
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exponent_accelerator_switch_ctrl.sv
// Directed and randomized bench for the switch controller with a read scoreboard.
module tb_exponent_accelerator_switch_ctrl;
    import exponent_accelerator_sw_pkg::*;

    localparam int WIDTH    = 10;
    localparam int STABLE_N = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              chipselect = 1'b0;
    logic [1:0]        address = 2'd0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [WIDTH-1:0]  in_port = '0;
    logic              irq;

    always #5 clk = ~clk;

    exponent_accelerator_switch_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic rd_issued = 1'b0;

    // Behavioural view: accepted levels, sticky rising edges, mask.
    logic [WIDTH-1:0] m_level = '0;
    logic [WIDTH-1:0] m_edge  = '0;
    logic [WIDTH-1:0] m_mask  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_issued <= chipselect & read;

    always @(negedge clk) begin
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got read data 0x%0h expected no read", readdata);
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.name, readdata, mon_e.val);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] e, input string n);
        chipselect = 1'b1; read = 1'b1; address = a;
        exp_q.push_back('{name: n, val: e});
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned      p;
        int unsigned      k;
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        logic [WIDTH-1:0] clr;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        idle(1);
        do_read(ADDR_PERIOD, 32'd50000, "rst_period");
        do_read(ADDR_DATA,   32'd0,     "rst_data");
        do_read(ADDR_MASK,   32'd0,     "rst_mask");
        do_read(ADDR_EDGE,   32'd0,     "rst_edge");

        // Exact acceptance latency with a tick every cycle
        do_write(ADDR_PERIOD, 32'd0);
        in_port = 10'h001;
        chipselect = 1'b1; read = 1'b1; address = ADDR_DATA;
        for (int i = 0; i <= 6; i++) begin
            exp_q.push_back('{name: "t2_data_timing", val: (i == 6) ? 32'd1 : 32'd0});
            @(posedge clk);
            @(negedge clk);
        end
        chipselect = 1'b0; read = 1'b0;
        m_level = 10'h001; m_edge = 10'h001;
        do_read(ADDR_EDGE, 32'd1, "t2_edge");
        check("t2_irq_masked", {31'd0, irq}, 32'd0);

        // Two-sample glitch is rejected
        do_write(ADDR_PERIOD, 32'd3);
        in_port[5] = 1'b1;
        idle(8);
        in_port[5] = 1'b0;
        idle(30);
        do_read(ADDR_DATA, 32'd1, "t3_data_glitch");
        do_read(ADDR_EDGE, 32'd1, "t3_edge_glitch");

        // Mask raises irq one cycle later; W1C drops it one cycle later
        do_write(ADDR_MASK, 32'd1);
        m_mask = 10'h001;
        check("t4_irq_same_cycle", {31'd0, irq}, 32'd0);
        idle(1);
        check("t4_irq_set", {31'd0, irq}, 32'd1);
        do_write(ADDR_EDGE, 32'd1);
        check("t4_irq_hold", {31'd0, irq}, 32'd1);
        idle(1);
        check("t4_irq_clear", {31'd0, irq}, 32'd0);
        do_read(ADDR_EDGE, 32'd0, "t4_edge_cleared");
        m_edge = '0;

        // Clear coinciding with a new event keeps the bit
        do_write(ADDR_PERIOD, 32'd0);
        in_port = 10'h000;
        idle(12);
        do_read(ADDR_DATA, 32'd0, "t5_data_fall");
        do_read(ADDR_EDGE, 32'd0, "t5_no_fall_edge");
        in_port = 10'h001;
        idle(5);
        do_write(ADDR_EDGE, 32'd1);
        do_read(ADDR_EDGE, 32'd1, "t5_edge_kept");
        check("t5_irq", {31'd0, irq}, 32'd1);

        // Reset in the middle of a CHANGING count
        in_port = 10'h000;
        idle(3);
        chipselect = 1'b1; read = 1'b1; address = ADDR_MASK;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{name: "t6_mask_before_rst", val: 32'd1});
            @(posedge clk);
            @(negedge clk);
        end
        #2;
        reset_n = 1'b0;
        chipselect = 1'b0; read = 1'b0;
        #1;
        check("t6_rst_readdata", readdata, 32'd0);
        check("t6_rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("t6_rst_readdata_edge", readdata, 32'd0);
        in_port = 10'h3A5;
        @(negedge clk);
        reset_n = 1'b1;
        m_level = '0; m_edge = '0; m_mask = '0;
        idle(3);
        do_read(ADDR_PERIOD, 32'd50000, "t6_period_reset");
        do_read(ADDR_DATA, 32'd0, "t6_data_reset");
        do_write(ADDR_PERIOD, 32'd0);
        chipselect = 1'b1; read = 1'b1; address = ADDR_DATA;
        for (int i = 0; i <= 5; i++) begin
            exp_q.push_back('{name: "t6_full_restart", val: (i >= 4) ? 32'h3A5 : 32'd0});
            @(posedge clk);
            @(negedge clk);
        end
        chipselect = 1'b0; read = 1'b0;
        m_level = 10'h3A5; m_edge = 10'h3A5;
        do_read(ADDR_EDGE, 32'h3A5, "t6_edge");

        // Randomized: glitches, level changes, masks, clears
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 5);
            do_write(ADDR_PERIOD, p);
            cur = in_port;
            in_port = cur ^ WIDTH'($urandom);
            k = $urandom_range(1, (STABLE_N - 1) * (p + 1));
            idle(int'(k));
            in_port = cur;
            idle(int'(p) + 4);
            nxt = WIDTH'($urandom);
            in_port = nxt;
            idle(4 + (STABLE_N + 1) * (int'(p) + 1));
            m_edge  = m_edge | (nxt & ~m_level);
            m_level = nxt;
            m_mask  = WIDTH'($urandom);
            do_write(ADDR_MASK, {22'd0, m_mask});
            idle(1);
            check("rnd_irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
            do_write(ADDR_DATA, 32'hFFFF_FFFF);
            do_read(ADDR_DATA,   {22'd0, m_level}, "rnd_data");
            do_read(ADDR_EDGE,   {22'd0, m_edge},  "rnd_edge");
            do_read(ADDR_MASK,   {22'd0, m_mask},  "rnd_mask");
            do_read(ADDR_PERIOD, p,                "rnd_period");
            clr = WIDTH'($urandom);
            do_write(ADDR_EDGE, {22'd0, clr});
            m_edge = m_edge & ~clr;
            idle(1);
            check("rnd_irq_after_clr", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
        end

        idle(3);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
